// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store controller between the MEM stage
// and a word-addressed data memory. One request is latched, the memory is
// driven for WAIT_CYCLES cycles with the pipeline frozen, then a single
// `ready` pulse returns the registered read data.
// Optional address range/alignment checking (err port) is enabled by
// defining MEM_CTRL_ADDR_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h400,
    parameter int unsigned DEPTH       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_r_en,
    input  logic        req_w_en,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_w_en,
    output logic        mem_r_en,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        freeze
`ifdef MEM_CTRL_ADDR_CHECK_EN
   ,output logic        err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q,    wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic        last;
    logic        access_ok;

    assign req  = req_r_en | req_w_en;
    assign last = (cnt_q == 4'd0);

`ifdef MEM_CTRL_ADDR_CHECK_EN
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    logic bad_q, bad_d;
    logic err_q, err_d;
    logic bad_now;

    assign bad_now   = (req_addr[1:0] != 2'b00)
                    || ({1'b0, req_addr} <  {1'b0, BASE_ADDR})
                    || ({1'b0, req_addr} >= ADDR_LIMIT);
    assign access_ok = ~bad_q;
    assign err       = err_q;
`else
    assign access_ok = 1'b1;
`endif

    assign rdata = rdata_q;

    // Next-state, latching and memory/pipeline handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
`ifdef MEM_CTRL_ADDR_CHECK_EN
        bad_d     = bad_q;
        err_d     = 1'b0;
`endif
        mem_addr  = '0;
        mem_wdata = '0;
        mem_w_en  = 1'b0;
        mem_r_en  = 1'b0;
        ready     = 1'b0;
        freeze    = 1'b0;

        case (state_q)
            IDLE: begin
                freeze = req & ~rst;
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // A store wins over a simultaneous load.
                    wr_d    = req_w_en;
                    cnt_d   = CNT_INIT;
`ifdef MEM_CTRL_ADDR_CHECK_EN
                    bad_d   = bad_now;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                freeze    = ~rst;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_r_en  = ~wr_q & access_ok & ~rst;
                // Single write strobe on the final access cycle only.
                mem_w_en  = wr_q & access_ok & last & ~rst;
                if (last) begin
                    rdata_d = (wr_q || !access_ok) ? '0 : mem_rdata;
`ifdef MEM_CTRL_ADDR_CHECK_EN
                    err_d   = bad_q;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Completing request may still be visible; never restart it.
                ready   = ~rst;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
`ifdef MEM_CTRL_ADDR_CHECK_EN
            bad_q   <= bad_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected completions
// and memory writes into queues; negedge monitors pop and compare.
// Define MEM_CTRL_ADDR_CHECK_EN to also exercise the err path.
module tb_mem_access_ctrl;

    localparam int unsigned W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_r_en;
    logic        req_w_en;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_w_en;
    logic        mem_r_en;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;
`ifdef MEM_CTRL_ADDR_CHECK_EN
    logic        err;
`endif

    mem_access_ctrl #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (32'h400),
        .DEPTH      (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_r_en (req_r_en),
        .req_w_en (req_w_en),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_w_en (mem_w_en),
        .mem_r_en (mem_r_en),
        .mem_rdata(mem_rdata),
        .rdata    (rdata),
        .ready    (ready),
`ifdef MEM_CTRL_ADDR_CHECK_EN
        .err      (err),
`endif
        .freeze   (freeze)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory: 64 words at byte base 0x400.
    logic [31:0] mem [0:63];
    logic [31:0] moff;
    logic        min_range;
    always_comb begin
        moff      = mem_addr - 32'h400;
        min_range = (mem_addr >= 32'h400) && (moff < 32'd256);
        mem_rdata = min_range ? mem[moff[7:2]] : '0;
    end
    always @(posedge clk) begin
        if (mem_w_en === 1'b1 && min_range) mem[moff[7:2]] <= mem_wdata;
    end

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int unsigned at;
    } cmp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int unsigned at;
    } wr_t;

    cmp_t exp_q[$];
    wr_t  wexp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion and write monitors.
    cmp_t me;
    wr_t  mw;
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {31'b0, ready}, 32'd0);
            end else begin
                me = exp_q.pop_front();
                chk("rdata_at_ready", rdata, me.rd);
                chk("ready_cycle", cyc, me.at);
`ifdef MEM_CTRL_ADDR_CHECK_EN
                chk("err_at_ready", {31'b0, err}, {31'b0, me.er});
`endif
            end
        end
        if (mem_w_en === 1'b1) begin
            if (wexp_q.size() == 0) begin
                chk("unexpected_write", {31'b0, mem_w_en}, 32'd0);
            end else begin
                mw = wexp_q.pop_front();
                chk("write_addr", mem_addr, mw.a);
                chk("write_data", mem_wdata, mw.d);
                chk("write_cycle", cyc, mw.at);
            end
        end
    end

    // One complete access; caller and return point are #1 after a posedge.
    task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd,
                             input logic good);
        int unsigned start;
        logic ld;
        ld        = r && !w;
        req_r_en  = r;
        req_w_en  = w;
        req_addr  = a;
        req_wdata = d;
        start     = cyc;
        exp_q.push_back('{rd: exp_rd, er: !good, at: start + W + 1});
        if (w && good) wexp_q.push_back('{a: a, d: d, at: start + W});
        for (int unsigned i = 0; i <= W + 1; i++) begin
            @(negedge clk);
            chk("freeze", {31'b0, freeze}, {31'b0, (i <= W)});
            chk("mem_r_en", {31'b0, mem_r_en}, {31'b0, (ld && good && i >= 1 && i <= W)});
            chk("mem_w_en", {31'b0, mem_w_en}, {31'b0, (w && good && i == W)});
            @(posedge clk); #1;
        end
        req_r_en = 1'b0;
        req_w_en = 1'b0;
        @(negedge clk);
        chk("freeze_after", {31'b0, freeze}, 32'd0);
        chk("rdata_hold", rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_r_en  = 1'b1;
        req_w_en  = 1'b0;
        req_addr  = 32'h404;
        req_wdata = '0;

        // Reset held two cycles with a load request present.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_freeze", {31'b0, freeze}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_mem_r_en", {31'b0, mem_r_en}, 32'd0);
        chk("rst_mem_w_en", {31'b0, mem_w_en}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        req_r_en = 1'b0;
        @(negedge clk);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_freeze", {31'b0, freeze}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;

        // Store then load back.
        do_access(1'b0, 1'b1, 32'h404, 32'hDEADBEEF, 32'd0, 1'b1);
        do_access(1'b1, 1'b0, 32'h404, 32'h0, 32'hDEADBEEF, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("rdata_stable", rdata, 32'hDEADBEEF);
            @(posedge clk); #1;
        end

        // Simultaneous enables: store wins, rdata completes as 0.
        do_access(1'b1, 1'b1, 32'h408, 32'h12345678, 32'd0, 1'b1);
        do_access(1'b1, 1'b0, 32'h408, 32'h0, 32'h12345678, 1'b1);

        // Reset in the final access cycle of a store.
        req_w_en  = 1'b1;
        req_addr  = 32'h404;
        req_wdata = 32'hCAFEF00D;
        repeat (W) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_w_en", {31'b0, mem_w_en}, 32'd0);
        chk("midrst_ready", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        req_w_en = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            chk("midrst_idle_freeze", {31'b0, freeze}, 32'd0);
            chk("midrst_idle_w_en", {31'b0, mem_w_en}, 32'd0);
            @(posedge clk); #1;
        end
        do_access(1'b1, 1'b0, 32'h404, 32'h0, 32'hDEADBEEF, 1'b1);

`ifdef MEM_CTRL_ADDR_CHECK_EN
        do_access(1'b1, 1'b0, 32'h402, 32'h0, 32'd0, 1'b0);
        do_access(1'b0, 1'b1, 32'h500, 32'h55AA55AA, 32'd0, 1'b0);
        do_access(1'b1, 1'b0, 32'h404, 32'h0, 32'hDEADBEEF, 1'b1);
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size() + wexp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
